// File: rtl/jpeg_bitpacker_if.sv
// Code-word input and stuffed byte-stream output bundle of the JPEG bit packer.
// The master side is the encoder/sink environment, the slave side is the packer.
interface jpeg_bitpacker_if;
    logic [5:0]  elen;
    logic [31:0] edata;
    logic        flush;
    logic        blk_ready;
    logic [7:0]  obyte;
    logic        ovalid;
    logic        oready;
    logic        flush_done;
    logic        overflow;

    modport master (
        output elen, edata, flush, oready,
        input  blk_ready, obyte, ovalid, flush_done, overflow
    );

    modport slave (
        input  elen, edata, flush, oready,
        output blk_ready, obyte, ovalid, flush_done, overflow
    );
endinterface

// File: rtl/jpeg_bitpacker.sv
// Packs variable-length codes MSB-first into 32-bit FIFO entries and emits
// a byte stream with 0xFF->0xFF00 stuffing; flush pads with 1s to a byte.
module jpeg_bitpacker #(
    parameter int FIFO_AW = 7,
    parameter int FREE_TH = 32
) (
    input logic             clk,
    input logic             rst,
    jpeg_bitpacker_if.slave io_bus
);
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DATA  = 2'd1;
    localparam logic [1:0] S_STUFF = 2'd2;

    logic [62:0]        r_acc;
    logic [5:0]         r_cnt;
    logic               r_fl_push;
    logic               r_fl_wait;
    logic               r_ovf;
    logic               r_blk;
    logic [35:0]        r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic [35:0]        r_nxt;
    logic               r_nxt_v;
    logic [1:0]         r_state;
    logic [31:0]        r_word;
    logic [2:0]         r_nb;
    logic [1:0]         r_idx;
    logic               r_last;
    logic               r_done;

    logic [5:0]  w_len;
    logic        w_in_bad;
    logic        w_flush_go;
    logic [63:0] w_mask;
    logic [63:0] w_cat;
    logic [6:0]  w_cnt_app;
    logic        w_full;
    logic [6:0]  w_sh;
    logic [31:0] w_word_full;
    logic [4:0]  w_rem;
    logic [2:0]  w_pad;
    logic [63:0] w_cat_pad;
    logic [5:0]  w_cnt_pad;
    logic [31:0] w_tail;
    logic        w_push;
    logic [35:0] w_entry;
    logic        w_fifo_full;
    logic        w_empty;
    logic        w_wr;
    logic        w_drop;
    logic        w_pop;
    logic        w_hs;
    logic        w_end;
    logic        w_fin;
    logic        w_take;
    logic        w_done_set;

    // Inputs arriving between a flush and its flush_done are discarded.
    always_comb begin
        w_in_bad   = r_fl_wait && (io_bus.elen != 6'd0 || io_bus.flush);
        w_len      = r_fl_wait ? 6'd0 : io_bus.elen;
        w_flush_go = io_bus.flush && !r_fl_wait;
        w_mask     = (64'd1 << w_len) - 64'd1;
        w_cat      = ({1'b0, r_acc} << w_len)
                   | ({32'd0, io_bus.edata} & w_mask);
        w_cnt_app  = {1'b0, r_cnt} + {1'b0, w_len};
        w_full     = (w_cnt_app >= 7'd32) && !r_fl_push;
        w_sh       = w_cnt_app - 7'd32;
        w_word_full = 32'(w_cat >> w_sh);
        w_rem      = w_full ? w_sh[4:0] : w_cnt_app[4:0];
        w_pad      = 3'd0 - w_rem[2:0];
        w_cat_pad  = (w_cat << w_pad) | ((64'd1 << w_pad) - 64'd1);
        w_cnt_pad  = {1'b0, w_rem} + {3'd0, w_pad};
        w_tail     = r_acc[31:0] << (6'd32 - r_cnt);
    end

    always_comb begin
        w_push  = w_full || r_fl_push;
        w_entry = r_fl_push ? {1'b1, r_cnt[5:3], w_tail}
                            : {1'b0, 3'd4, w_word_full};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_fl_push <= 1'b0;
        end else if (r_fl_push) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_fl_push <= 1'b0;
        end else if (w_flush_go) begin
            r_acc     <= 63'(w_cat_pad);
            r_cnt     <= w_cnt_pad;
            r_fl_push <= 1'b1;
        end else begin
            r_acc     <= 63'(w_cat);
            r_cnt     <= {1'b0, w_rem};
        end
    end

    always_comb begin
        w_fifo_full = r_count == (FIFO_AW+1)'(DEPTH);
        w_empty     = r_count == '0;
        w_wr        = w_push && (!w_fifo_full || w_pop);
        w_drop      = w_push && w_fifo_full && !w_pop;
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wptr] <= w_entry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_blk   <= 1'b0;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            unique case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_blk <= (DEPTH - int'(r_count)) >= FREE_TH;
        end
    end

    // A finished entry hands over to the prefetched one in the same cycle.
    always_comb begin
        w_hs   = (r_state != S_IDLE) && io_bus.oready;
        w_end  = ({1'b0, r_idx} + 3'd1) == r_nb;
        w_fin  = w_hs && w_end
               && (r_state == S_STUFF
                   || (r_state == S_DATA && r_word[31:24] != 8'hFF));
        w_take = r_nxt_v && (r_state == S_IDLE || w_fin);
        w_pop  = !w_empty && (!r_nxt_v || w_take);
        w_done_set = (w_fin && r_last)
                   || (w_take && r_nxt[34:32] == 3'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_nxt     <= '0;
            r_nxt_v   <= 1'b0;
            r_state   <= S_IDLE;
            r_word    <= '0;
            r_nb      <= '0;
            r_idx     <= '0;
            r_last    <= 1'b0;
            r_done    <= 1'b0;
            r_fl_wait <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= w_done_set;
            r_ovf  <= r_ovf | w_drop | w_in_bad;
            if (w_flush_go)
                r_fl_wait <= 1'b1;
            else if (w_done_set)
                r_fl_wait <= 1'b0;
            if (w_pop) begin
                r_nxt   <= r_mem[r_rptr];
                r_nxt_v <= 1'b1;
            end else if (w_take) begin
                r_nxt_v <= 1'b0;
            end
            if (w_take) begin
                r_word  <= r_nxt[31:0];
                r_nb    <= r_nxt[34:32];
                r_last  <= r_nxt[35];
                r_idx   <= '0;
                r_state <= (r_nxt[34:32] == 3'd0) ? S_IDLE : S_DATA;
            end else if (w_fin) begin
                r_state <= S_IDLE;
            end else if (w_hs) begin
                if (r_state == S_DATA && r_word[31:24] == 8'hFF) begin
                    r_state <= S_STUFF;
                end else begin
                    r_state <= S_DATA;
                    r_idx   <= r_idx + 1'b1;
                    r_word  <= {r_word[23:0], 8'h00};
                end
            end
        end
    end

    assign io_bus.obyte      = (r_state == S_DATA) ? r_word[31:24] : 8'h00;
    assign io_bus.ovalid     = r_state != S_IDLE;
    assign io_bus.blk_ready  = r_blk;
    assign io_bus.flush_done = r_done;
    assign io_bus.overflow   = r_ovf;
endmodule

// File: tb/tb_jpeg_bitpacker.sv
// Directed bench for jpeg_bitpacker: packing, stuffing, flush padding,
// backpressure, overflow and reset behaviour against hand-computed bytes.
module tb_jpeg_bitpacker;
    localparam int AW    = 7;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b0;

    jpeg_bitpacker_if bus ();

    jpeg_bitpacker #(.FIFO_AW(AW), .FREE_TH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] q_got [$];
    logic [7:0] q_exp [$];
    int n_done;
    int n_gap;
    int n_unstable;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] len, input logic [31:0] data,
                        input logic fl);
        bus.elen  = len;
        bus.edata = data;
        bus.flush = fl;
        tick();
        bus.elen  = '0;
        bus.edata = '0;
        bus.flush = 1'b0;
    endtask

    // mode 0: oready held high; mode 1: oready pattern 1,0,0 repeating
    task automatic drain(input int ncyc, input int mode);
        logic [7:0] pb;
        bit stall;
        int pend;
        pb = '0;
        stall = 0;
        pend = 0;
        q_got.delete();
        n_done = 0;
        n_gap = 0;
        n_unstable = 0;
        for (int i = 0; i < ncyc; i++) begin
            bus.oready = (mode == 0) ? 1'b1 : (i % 3 == 0);
            if (stall && (!bus.ovalid || bus.obyte !== pb))
                n_unstable++;
            if (bus.flush_done)
                n_done++;
            if (bus.ovalid && bus.oready) begin
                q_got.push_back(bus.obyte);
                n_gap += pend;
                pend = 0;
            end else if (bus.oready && !bus.ovalid && q_got.size() > 0) begin
                pend++;
            end
            stall = bus.ovalid && !bus.oready;
            pb = bus.obyte;
            tick();
        end
        bus.oready = 1'b0;
    endtask

    task automatic cmp_bytes(input string tag);
        chk({tag, "_n"}, q_got.size(), q_exp.size());
        for (int i = 0; i < q_exp.size(); i++)
            chk($sformatf("%s_b%0d", tag, i),
                (i < q_got.size()) ? {24'd0, q_got[i]} : 32'hDEAD,
                {24'd0, q_exp[i]});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.elen   = '0;
        bus.edata  = '0;
        bus.flush  = 1'b0;
        bus.oready = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bus.elen   = 6'($urandom_range(0, 32));
            bus.edata  = $urandom;
            bus.flush  = 1'($urandom);
            bus.oready = 1'($urandom);
            #1;
            chk("rst_out",
                {bus.blk_ready, bus.ovalid, bus.obyte,
                 bus.flush_done, bus.overflow}, 0);
        end
        bus.elen   = '0;
        bus.edata  = '0;
        bus.flush  = 1'b0;
        bus.oready = 1'b0;
        rst = 1'b1;
        #1;
        chk("blk_pre", bus.blk_ready, 0);
        tick();
        chk("blk_post", bus.blk_ready, 1);
        chk("ovalid_post", bus.ovalid, 0);

        bus.oready = 1'b1;
        send(8, 32'h12, 0);
        send(8, 32'h34, 0);
        send(8, 32'h56, 0);
        send(8, 32'h78, 0);
        chk("lat0", bus.ovalid, 0);
        tick();
        chk("lat1", bus.ovalid, 0);
        tick();
        chk("lat2", bus.ovalid, 1);
        chk("lat2_byte", bus.obyte, 8'h12);
        drain(10, 0);
        q_exp = '{8'h12, 8'h34, 8'h56, 8'h78};
        cmp_bytes("pack");
        chk("pack_done", n_done, 0);
        chk("pack_gap", n_gap, 0);

        send(32, 32'h11223344, 0);
        send(32, 32'h55667788, 0);
        drain(20, 0);
        q_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        cmp_bytes("two");
        chk("two_gap", n_gap, 0);
        chk("two_done", n_done, 0);

        send(16, 32'hFFFF, 0);
        send(16, 32'h0001, 0);
        send(0, 32'h0, 1);
        drain(30, 0);
        q_exp = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h01};
        cmp_bytes("stuff");
        chk("stuff_done", n_done, 1);
        chk("stuff_gap", n_gap, 0);

        send(3, 32'hFFFF_FFF5, 1);
        drain(20, 0);
        q_exp = '{8'hBF};
        cmp_bytes("pad");
        chk("pad_done", n_done, 1);

        send(0, 32'h0, 1);
        drain(20, 0);
        q_exp.delete();
        cmp_bytes("empty");
        chk("empty_done", n_done, 1);

        send(24, 32'hABCDEF, 0);
        send(24, 32'h123456, 0);
        send(0, 32'h0, 1);
        drain(40, 1);
        q_exp = '{8'hAB, 8'hCD, 8'hEF, 8'h12, 8'h34, 8'h56};
        cmp_bytes("bp");
        chk("bp_done", n_done, 1);
        chk("bp_stable", n_unstable, 0);
        chk("ovf_clean", bus.overflow, 0);

        bus.oready = 1'b0;
        for (int i = 0; i < DEPTH + 8; i++) begin
            send(32, 32'(i), 0);
            if (i == 3)
                chk("ovf_blk_hi", bus.blk_ready, 1);
            if (i == DEPTH - 1) begin
                chk("ovf_early", bus.overflow, 0);
                chk("ovf_blk_lo", bus.blk_ready, 0);
            end
        end
        chk("ovf_set", bus.overflow, 1);
        tick();
        tick();
        chk("ovf_sticky", bus.overflow, 1);

        rst = 1'b0;
        #1;
        chk("ovf_rst", bus.overflow, 0);
        chk("ovf_rst_valid", bus.ovalid, 0);
        chk("ovf_rst_blk", bus.blk_ready, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("ovf_rel_blk", bus.blk_ready, 1);
        drain(10, 0);
        q_exp.delete();
        cmp_bytes("ovf_flushed");
        chk("ovf_rel_ovf", bus.overflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
